// File: rtl/tmds_pkg.sv
// tmds_pkg: control tokens, token lookup and FSM states shared by the TMDS encoder and decoder
package tmds_pkg;

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    typedef enum logic {HUNT, LOCKED} state_t;

    function automatic logic [9:0] cd_to_token(input logic [1:0] cd);
        return cd == 2'd0 ? CTRL_00 : cd == 2'd1 ? CTRL_01 : cd == 2'd2 ? CTRL_10 : CTRL_11;
    endfunction

endpackage

// File: rtl/tmds_word_align.sv
// tmds_word_align: keeps the previous deserialized word and extracts the 10-bit symbol at the current bit offset
module tmds_word_align (
    input  logic       pixclk,
    input  logic       reset_n,
    input  logic [9:0] raw_word,
    input  logic [3:0] offset,
    output logic [9:0] sym
);

    logic [9:0]  prev;
    logic [19:0] window;

    // prev holds the earlier bits, so higher offsets reach into the newer word
    assign window = {raw_word, prev};

    always_ff @(posedge pixclk or negedge reset_n) begin
        if (!reset_n) begin
            prev <= '0;
            sym  <= '0;
        end else begin
            prev <= raw_word;
            sym  <= window[{1'b0, offset} +: 10];
        end
    end

endmodule

// File: rtl/tmds_decoder.sv
// tmds_decoder: per-channel TMDS receiver -- hunts symbol alignment on control tokens, decodes symbols, supervises lock
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_RUN     = 8,
    parameter int SLIP_WAIT    = 64,
    parameter int LOSS_TIMEOUT = 4095
) (
    input  logic       pixclk,
    input  logic       reset_n,
    input  logic [9:0] raw_word,
    output logic [7:0] data,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic       locked,
    output logic [3:0] offset,
    output logic       lock_lost
);

    localparam int RW = $clog2(LOCK_RUN) + 1;
    localparam int SW = $clog2(SLIP_WAIT) + 1;
    localparam int LW = $clog2(LOSS_TIMEOUT + 1);

    logic [9:0]    sym;
    state_t        state;
    logic [RW-1:0] run_cnt;
    logic [SW-1:0] slip_cnt;
    logic [LW-1:0] loss_cnt;
    logic          skip;
    logic          is_tok;
    logic          tok;
    logic          lock_hit;
    logic          slip;
    logic          timeout;
    logic [1:0]    tok_cd;
    logic [7:0]    q;
    logic [7:0]    dec;

    tmds_word_align u_align (
        .pixclk   (pixclk),
        .reset_n  (reset_n),
        .raw_word (raw_word),
        .offset   (offset),
        .sym      (sym)
    );

    always_comb begin
        is_tok = 1'b0;
        tok_cd = 2'd0;
        for (int i = 0; i < 4; i++)
            if (sym == cd_to_token(2'(i))) begin
                is_tok = 1'b1;
                tok_cd = 2'(i);
            end
    end

    assign q   = sym[9] ? ~sym[7:0] : sym[7:0];
    assign dec = {q[7:1] ^ q[6:0] ^ {7{~sym[8]}}, q[0]};

    // the symbol right after a slip was still cut at the old offset
    assign tok      = is_tok && !skip;
    assign lock_hit = state == HUNT && tok && run_cnt + RW'(1) == RW'(LOCK_RUN);
    assign slip     = state == HUNT && !lock_hit && slip_cnt == SW'(SLIP_WAIT - 1);
    assign timeout  = state == LOCKED && !is_tok && loss_cnt >= LW'(LOSS_TIMEOUT - 1);
    assign locked   = state == LOCKED;

    always_ff @(posedge pixclk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= HUNT;
            run_cnt   <= '0;
            slip_cnt  <= '0;
            loss_cnt  <= '0;
            skip      <= 1'b0;
            offset    <= '0;
            data      <= '0;
            hsync     <= 1'b0;
            vsync     <= 1'b0;
            active    <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            lock_lost <= timeout;
            skip      <= slip;
            if (state == HUNT) begin
                state    <= lock_hit ? LOCKED : HUNT;
                run_cnt  <= (tok && !slip && !lock_hit) ? run_cnt + RW'(1) : '0;
                slip_cnt <= (slip || lock_hit) ? '0 : slip_cnt + SW'(1);
                offset   <= slip ? (offset == 4'd9 ? 4'd0 : offset + 4'd1) : offset;
                loss_cnt <= '0;
                active   <= 1'b0;
                data     <= '0;
                hsync    <= 1'b0;
                vsync    <= 1'b0;
            end else if (timeout) begin
                state    <= HUNT;
                run_cnt  <= '0;
                slip_cnt <= '0;
                loss_cnt <= '0;
                active   <= 1'b0;
                data     <= '0;
                hsync    <= 1'b0;
                vsync    <= 1'b0;
            end else if (is_tok) begin
                loss_cnt <= '0;
                active   <= 1'b0;
                data     <= '0;
                hsync    <= tok_cd[0];
                vsync    <= tok_cd[1];
            end else begin
                loss_cnt <= loss_cnt == LW'(LOSS_TIMEOUT) ? loss_cnt : loss_cnt + LW'(1);
                active   <= 1'b1;
                data     <= dec;
            end
        end
    end

endmodule
